slot_buffer_decoder: RTL
========================

Name: slot_buffer_decoder

Overview:
- Receive-side counterpart of the 4-slot rotating inverting buffer.
- Accepts the inverted, slot-rotated byte stream, re-inverts each beat, checks frame alignment against a slot-0 sync marker, and buffers beats in a DEPTH-entry ring.
- Presents the recovered bytes in order on a ready/valid output to the downstream consumer.

Parameters:
WIDTH, 8, data width in bits
DEPTH, 4, slots per frame and ring entries; power of two, 2 or more
PTR_W, $clog2(DEPTH), pointer and slot-index width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
clear  input  1  asynchronous active-high reset
in_data  input  WIDTH  inverted encoded byte
in_valid  input  1  in_data valid
in_sync  input  1  marks the beat as frame slot 0; sampled only with in_valid
in_ready  output  1  decoder can accept a beat
out_data  output  WIDTH  recovered byte (~in_data of the stored beat)
out_sof  output  1  out_data was slot 0 of its frame
out_valid  output  1  out_data/out_sof valid
out_ready  input  1  consumer accepts the beat
locked  output  1  frame alignment established
sync_err  output  1  one-cycle pulse on an alignment violation

Behaviour:
- Reset: clock is clk. Reset is clear, asynchronous and active-high. While clear is asserted, all state is forced to zero immediately:
  - pointers, count, slot counter, locked;
  - out_valid=0, sync_err=0, out_data=0, out_sof=0.
- in_ready = (count != DEPTH). It is independent of out_ready; there is no write-through when full.
- Accepted beat: in_valid && in_ready. Acceptance condition by state:
  - Unlocked (hunting): only a beat with in_sync=1 is accepted into the ring. It sets locked=1 and slot=1. Non-sync beats are dropped silently, with no sync_err.
  - Locked, slot==0, in_sync=1: normal case; beat is stored.
  - Locked, slot!=0, in_sync=0: normal case; beat is stored.
  - Locked, slot==0, in_sync=0: violation. Beat dropped, locked cleared, sync_err pulses next cycle. Ring contents are kept.
  - Locked, slot!=0, in_sync=1: violation, realign. The ring is flushed (rd=wr=count=0). The current beat is stored as slot 0 with sof=1 (count becomes 1), slot=1, locked stays 1, and sync_err pulses next cycle.
- Stored entry = {sof, ~in_data}, written at wr_ptr. wr_ptr increments mod DEPTH.
- Slot counter advances on every stored beat and wraps DEPTH-1 to 0.
- Output side:
  - out_valid = (count != 0).
  - out_data and out_sof are a combinational read of entry[rd_ptr].
  - When out_valid && out_ready, rd_ptr increments mod DEPTH.
- Count update:
  - +1 on store only, -1 on pop only, unchanged when both happen in the same cycle.
  - A flush overrides any same-cycle pop; the popped entry is discarded.
- Latency: a beat accepted at edge N is visible on out_valid after edge N, i.e. one cycle.
- sync_err is registered: exactly one cycle high per violation, never two consecutive cycles for one event.
- Full: with count==DEPTH, in_ready=0 and in_valid is ignored, including in_sync. The slot counter does not advance.
- Empty: out_valid=0; out_data holds the stale entry value and must be ignored.
- clear asserted mid-frame discards all buffered data. After release the decoder is hunting (locked=0).

Decomposition:
- Shared package slot_codec_pkg holds:
  - constants SLOT_DEPTH=4 and SLOT_WIDTH=8, shared with the encoder;
  - typedef slot_entry_t = struct {logic sof; logic [WIDTH-1:0] data;}.
- One natural sub-module: slot_ring_buffer. It is the DEPTH-entry storage plus rd/wr/count logic with push, pop and flush inputs.
- The top level holds the slot counter, lock/sync checker and inversion.

Test Plan:
- Basic decode (reset, then hold out_ready=1): drive sync beat 8'hFE, then 8'hFD, 8'hFC, 8'hFB. Required: out_data 8'h01,02,03,04 one cycle after each; out_sof=1 on 8'h01 only; locked=1 from the first beat.
- Hunting: 8'h55 without sync, then sync 8'hAA. Required: 8'h55 dropped, no sync_err; single output 8'h55 (~AA) with sof=1.
- Full/backpressure: out_ready=0, sync plus 4 beats, then a 5th beat. Required: in_ready=0 after the 4th beat and the 5th beat is not consumed. Then raise out_ready for one cycle: in_ready=1 and the 5th beat is accepted.
- Missing sync: locked, 4 beats, then a 5th beat without sync. Required: sync_err pulse of 1 cycle, locked=0, 5th beat not output, earlier 4 still drain.
- Early sync at slot 2 with 2 entries buffered. Required: flush; next output is the new beat with sof=1; sync_err one cycle; locked stays 1.
- Async clear: assert clear between clock edges with count=3. Required: out_valid=0 and locked=0 before the next edge; hunting after release.

Source files
------------

// File: rtl/slot_codec_pkg.sv
// Shared definitions for the 4-slot rotating inverting codec (encoder and decoder).
package slot_codec_pkg;
  localparam int SLOT_DEPTH = 4;
  localparam int SLOT_WIDTH = 8;

  typedef struct packed {
    logic                  sof;
    logic [SLOT_WIDTH-1:0] data;
  } slot_entry_t;
endpackage

// File: rtl/slot_ring_buffer.sv
// DEPTH-entry ring of {sof, data} words with push/pop/flush; flush wins over pop
// and a same-cycle push lands at entry 0 of the emptied ring.
module slot_ring_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           clear,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  logic [WIDTH:0] wdata,
  output logic [WIDTH:0] rdata,
  output logic [PTR_W:0] count
);
  logic [DEPTH-1:0][WIDTH:0] mem_q, mem_d;
  logic [PTR_W-1:0]          rd_q, rd_d, wr_q, wr_d, wbase;
  logic [PTR_W:0]            cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else if (pop) begin
      rd_d  = rd_q + 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
    wbase = flush ? '0 : wr_q;
    if (push) begin
      mem_d[wbase] = wdata;
      wr_d         = wbase + 1'b1;
      cnt_d        = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/slot_buffer_decoder.sv
// Receive side of the rotating inverting buffer: re-inverts beats, tracks frame
// alignment against the slot-0 sync marker and buffers recovered bytes in a ring.
module slot_buffer_decoder
  import slot_codec_pkg::*;
#(
  parameter int WIDTH = SLOT_WIDTH,
  parameter int DEPTH = SLOT_DEPTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             locked,
  output logic             sync_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH;

  logic [PTR_W-1:0] slot_q, slot_d;
  logic             locked_q, locked_d;
  logic             sync_err_q, sync_err_d;
  logic             push, pop, flush, accept;
  logic [PTR_W:0]   count;
  logic [WIDTH:0]   rdata;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    push       = 1'b0;
    flush      = 1'b0;
    sync_err_d = 1'b0;
    locked_d   = locked_q;
    slot_d     = slot_q;
    if (accept) begin
      if (!locked_q) begin
        // Hunting: only a sync beat starts a frame; everything else vanishes quietly.
        if (in_sync) begin
          push     = 1'b1;
          locked_d = 1'b1;
          slot_d   = PTR_W'(1);
        end
      end else if ((slot_q == '0) == in_sync) begin
        push   = 1'b1;
        slot_d = slot_q + 1'b1;
      end else if (!in_sync) begin
        locked_d   = 1'b0;
        sync_err_d = 1'b1;
      end else begin
        // Early sync: realign on this beat, discarding the partial frame.
        flush      = 1'b1;
        push       = 1'b1;
        slot_d     = PTR_W'(1);
        sync_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      slot_q     <= '0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
    end
  end

  slot_ring_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_ring (
    .clk   (clk),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({in_sync, ~in_data}),
    .rdata (rdata),
    .count (count)
  );

  assign out_sof  = rdata[WIDTH];
  assign out_data = rdata[WIDTH-1:0];
  assign locked   = locked_q;
  assign sync_err = sync_err_q;
endmodule
